usr_burst_shifter: RTL and testbench
====================================

// Module: usr_burst_shifter
// PURPOSE
//  Parametrised universal shift register: WIDTH-bit data, 8 modes including rotate,
//  arithmetic shift and clear, plus a counted burst engine that performs N shifts
//  autonomously after a start pulse. Serves as the generic register in datapaths
//  needing serial<->parallel conversion or multi-position shifts without external sequencing.
// PARAMETERS
//  WIDTH  8  data width in bits (>=2)
//  CNT_W  4  burst count width; 2**CNT_W must exceed WIDTH
// PORTS
//  clk    in   1        clock; all state changes on rising edge
//  reset  in   1        asynchronous, active-high reset
//  en     in   1        op enable (IDLE: execute mode; BUSY: 0 stalls the burst)
//  mode   in   3        operation select (table below)
//  I      in   WIDTH    parallel load data
//  sin_l  in   1        serial in, enters bit 0 on shift left
//  sin_r  in   1        serial in, enters bit WIDTH-1 on shift right
//  start  in   1        burst request (sampled in IDLE only)
//  count  in   CNT_W    burst length in shifts
//  O      out  WIDTH    register contents
//  sout_l out  1        O[WIDTH-1] (combinational)
//  sout_r out  1        O[0] (combinational)
//  busy   out  1        1 while in BUSY
//  done   out  1        one-cycle pulse at burst completion
// BEHAVIOUR
//  Modes: 000 hold; 001 SHL {O[W-2:0],sin_l}; 010 SHR {sin_r,O[W-1:1]};
//   011 load I; 100 ROL {O[W-2:0],O[W-1]}; 101 ROR {O[0],O[W-1:1]};
//   110 ASR {O[W-1],O[W-1:1]}; 111 clear to 0.
//  Shift modes = 001,010,100,101,110.
//  Reset (async, any state): O=0, busy=0, done=0, state=IDLE; in-flight burst abandoned.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - start=1, shift mode, count>0: latch mode->bmode, count->remaining; go BUSY.
//     O unchanged on this edge; first shift on the next edge.
//   - start=1, shift mode, count=0: go DONE, O unchanged.
//   - start=1, non-shift mode: start ignored; single op below.
//   - otherwise: en=1 applies mode once (1-cycle latency); en=0 holds.
//  BUSY:
//   - Each edge with en=1 applies bmode and decrements remaining.
//   - Edge applying the last shift (remaining==1) moves to DONE.
//   - en=0 holds O and remaining.
//   - mode, I, start and count inputs are ignored; sin_l/sin_r are live each cycle.
//  DONE: done=1 for exactly one cycle, O held; next edge -> IDLE (start ignored in DONE).
//  busy = (state==BUSY).
//  Burst of count=N on WIDTH bits equals N single ops; N>=WIDTH permitted
//   (rotates wrap, SHL/SHR fully refill from serial inputs).
// TESTING
//  1 load: mode=011, I=8'hA5, en=1, one edge -> O=8'hA5; then mode=000, 3 edges -> O stays 8'hA5.
//  2 single ops from O=8'h81, one op each from reload:
//    SHL sin_l=1 -> 8'h03; SHR sin_r=0 -> 8'h40; ROL -> 8'h03; ROR -> 8'hC0; ASR -> 8'hC0; clear -> 8'h00.
//  3 burst: O=8'h96, start=1, mode=100, count=3 -> busy 3 cycles, O=8'hB4, done pulse 1 cycle, then IDLE.
//  4 stall + zero count:
//    - burst SHR count=4, sin_r=1 from O=8'h00, en=0 for 2 mid-burst cycles
//      -> busy 6 cycles, O=8'hF0;
//    - start with count=0 -> done next cycle, O unchanged, busy never set.
//  5 reset mid-burst: ROL count=7 on O=8'h01, assert reset after 2 shifts
//    -> O=0, busy=0, no done; next start works normally.
//  6 ignored inputs: during a BUSY burst, drive start=1, mode=011, I=8'hFF
//    -> no load; burst result equals the undisturbed case.

Source files
------------

// File: rtl/usr_burst_shifter.sv
// rtl/usr_burst_shifter.sv - universal shift register with counted burst engine
module usr_burst_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] O,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic [2:0]       bmode_q;
  logic [2:0]       op_sel;
  logic [CNT_W-1:0] rem_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
           (op == 3'b101) || (op == 3'b110);
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    case (op)
      3'b000:  return cur;
      3'b001:  return {cur[WIDTH-2:0], sl};
      3'b010:  return {sr, cur[WIDTH-1:1]};
      3'b011:  return ld;
      3'b100:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  return {cur[0], cur[WIDTH-1:1]};
      3'b110:  return {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: return '0;
    endcase
  endfunction

  // Serial inputs stay live during a burst; only the op is frozen into bmode_q.
  assign op_sel = (state_q == S_BUSY) ? bmode_q : mode;
  assign o_d    = apply_op(op_sel, o_q, I, sin_l, sin_r);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      bmode_q <= 3'b000;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_shift(mode)) begin
            if (count != '0) begin
              bmode_q <= mode;
              rem_q   <= count;
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (en) begin
            o_q <= o_d;
          end
        end
        S_BUSY: begin
          if (en) begin
            o_q   <= o_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign O      = o_q;
  assign sout_l = o_q[WIDTH-1];
  assign sout_r = o_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_usr_burst_shifter.sv
// tb/tb_usr_burst_shifter.sv - randomized and directed bench for usr_burst_shifter
module tb_usr_burst_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] I;
  logic       sin_l;
  logic       sin_r;
  logic       start;
  logic [3:0] count;
  logic [7:0] O;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_o;
  int bc;

  usr_burst_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .I(I),
    .sin_l(sin_l), .sin_r(sin_r), .start(start), .count(count),
    .O(O), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference op: plain arithmetic on an 8-bit value.
  function automatic logic [7:0] ref_op(input logic [2:0] md, input logic [7:0] o,
                                        input logic [7:0] ld, input logic sl, input logic sr);
    int v;
    v = int'(o);
    case (md)
      3'd0: return o;
      3'd1: return 8'(((v * 2) + int'(sl)) % 256);
      3'd2: return 8'((v / 2) + int'(sr) * 128);
      3'd3: return ld;
      3'd4: return 8'(((v * 2) % 256) + (v / 128));
      3'd5: return 8'((v / 2) + (v % 2) * 128);
      3'd6: return 8'((v / 2) + (v / 128) * 128);
      default: return 8'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    start = 1'b0; en = 1'b1; mode = 3'd3; I = v;
    tick;
    m_o = v;
    en = 1'b0; mode = 3'd0;
  endtask

  task automatic burst(input logic [2:0] md, input logic [3:0] n, input int stall_after,
                       input bit rand_stall, input bit rnd_sin, input bit disturb,
                       output int busy_cnt);
    int rem;
    int done_sh;
    int stall_left;
    bit inserted;
    bit e;
    rem = int'(n); done_sh = 0; stall_left = 0; inserted = 0; busy_cnt = 0;
    mode = md; count = n; start = 1'b1; en = 1'b1;
    tick;
    chk("burst_start_O", O, m_o);
    chk("burst_start_busy", busy, n != 0);
    chk("burst_start_done", done, n == 0);
    if (busy) busy_cnt++;
    for (int cyc = 0; cyc < 100 && rem > 0; cyc++) begin
      if (!inserted && done_sh == stall_after) begin stall_left = 2; inserted = 1; end
      if (stall_left > 0) begin e = 0; stall_left--; end
      else if (rand_stall) e = ($urandom_range(0, 2) != 0);
      else e = 1;
      en = e;
      if (rnd_sin) begin sin_l = 1'($urandom); sin_r = 1'($urandom); end
      if (disturb) begin start = 1'b1; mode = 3'd3; I = 8'hFF; count = 4'd0; end
      else begin start = 1'b0; mode = md; end
      tick;
      if (e) begin m_o = ref_op(md, m_o, 8'h00, sin_l, sin_r); rem--; done_sh++; end
      if (busy) busy_cnt++;
      chk("burst_O", O, m_o);
      chk("burst_busy", busy, rem > 0);
      chk("burst_done", done, rem == 0);
    end
    chk("burst_timeout_rem", rem, 0);
    start = 1'b0; en = 1'b0; mode = 3'd0;
    tick;
    chk("burst_after_done", done, 1'b0);
    chk("burst_after_busy", busy, 1'b0);
    chk("burst_after_O", O, m_o);
  endtask

  logic [2:0] ops2 [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] exp2 [6] = '{8'h03, 8'h40, 8'h03, 8'hC0, 8'hC0, 8'h00};
  logic [2:0] shm  [5] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

  initial begin
    reset = 1'b1; en = 1'b0; mode = 3'd0; I = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; count = 4'd0;
    m_o = 8'h00;
    repeat (2) tick;
    chk("reset_O", O, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0;

    load(8'hA5);
    chk("load_A5", O, 8'hA5);
    en = 1'b1; mode = 3'd0;
    for (int k = 0; k < 3; k++) begin tick; chk("hold_A5", O, 8'hA5); end
    en = 1'b0; mode = 3'd1;
    tick;
    chk("en0_holds", O, 8'hA5);

    for (int k = 0; k < 6; k++) begin
      load(8'h81);
      sin_l = 1'b1; sin_r = 1'b0; en = 1'b1; mode = ops2[k];
      tick;
      m_o = ref_op(ops2[k], m_o, I, sin_l, sin_r);
      chk("single_op_model", O, m_o);
      chk("single_op_table", O, exp2[k]);
      chk("sout_l", sout_l, m_o[7]);
      chk("sout_r", sout_r, m_o[0]);
    end

    start = 1'b1; en = 1'b1; mode = 3'd3; I = 8'h5A;
    tick;
    m_o = 8'h5A;
    chk("start_nonshift_load", O, 8'h5A);
    chk("start_nonshift_busy", busy, 1'b0);
    start = 1'b0; en = 1'b0;

    load(8'h96);
    burst(3'd4, 4'd3, -1, 0, 0, 0, bc);
    chk("rol3_busy_cycles", bc, 3);
    chk("rol3_result", O, 8'hB4);

    load(8'h00);
    sin_r = 1'b1;
    burst(3'd2, 4'd4, 2, 0, 0, 0, bc);
    chk("shr_stall_busy_cycles", bc, 6);
    chk("shr_stall_result", O, 8'hF0);

    burst(3'd1, 4'd0, -1, 0, 0, 0, bc);
    chk("zero_count_busy", bc, 0);
    chk("zero_count_O", O, 8'hF0);

    load(8'h01);
    mode = 3'd4; count = 4'd7; start = 1'b1; en = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    chk("pre_reset_O", O, 8'h04);
    reset = 1'b1;
    #1;
    chk("async_reset_O", O, 8'h00);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_done", done, 1'b0);
    #1 reset = 1'b0;
    en = 1'b0;
    tick;
    m_o = 8'h00;
    chk("post_reset_done", done, 1'b0);
    chk("post_reset_busy", busy, 1'b0);
    load(8'h01);
    burst(3'd4, 4'd7, -1, 0, 0, 0, bc);
    chk("post_reset_burst", O, 8'h80);

    load(8'h96);
    burst(3'd4, 4'd3, -1, 0, 0, 1, bc);
    chk("disturbed_result", O, 8'hB4);

    for (int it = 0; it < 25; it++) begin
      load(8'($urandom));
      for (int s = 0; s < 4; s++) begin
        mode = 3'($urandom); en = 1'($urandom); I = 8'($urandom);
        sin_l = 1'($urandom); sin_r = 1'($urandom); start = 1'b0;
        tick;
        if (en) m_o = ref_op(mode, m_o, I, sin_l, sin_r);
        chk("rand_single", O, m_o);
      end
      burst(shm[$urandom_range(0, 4)], 4'($urandom_range(0, 12)), -1, 1, 1,
            1'($urandom), bc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
